// File: rtl/vm_pkg.sv
// Shared definitions for the vending machine panel arbiter: code widths,
// product/denomination constants and the arbiter state type.
package vm_pkg;
  localparam int unsigned CODE_W               = 4;
  localparam int unsigned MAX_PRODUCT_CODE_DEF = 8;

  localparam logic [CODE_W-1:0] PRODUCT_NONE = 4'd0;

  localparam logic [CODE_W-1:0] DENOM_NONE = 4'd0;
  localparam logic [CODE_W-1:0] DENOM_100  = 4'd1;
  localparam logic [CODE_W-1:0] DENOM_200  = 4'd2;
  localparam logic [CODE_W-1:0] DENOM_500  = 4'd3;
  localparam logic [CODE_W-1:0] DENOM_1000 = 4'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    MONEY  = 2'd2,
    DRAIN  = 2'd3
  } arb_state_t;
endpackage

// File: rtl/vm_panel_arbiter_if.sv
// Panel-side and core-side signal bundle of the panel arbiter.
interface vm_panel_arbiter_if #(
  parameter int unsigned N_PANELS = 4
);
  logic [N_PANELS-1:0]   i_req;
  logic [4*N_PANELS-1:0] i_req_product_code;
  logic [4*N_PANELS-1:0] i_req_money;
  logic [N_PANELS-1:0]   i_req_money_valid;
  logic [N_PANELS-1:0]   o_gnt;
  logic [N_PANELS-1:0]   o_money_ready;
  logic [N_PANELS-1:0]   o_reject;
  logic [N_PANELS-1:0]   o_done;
  logic [N_PANELS-1:0]   o_panel_product_valid;
  logic [N_PANELS-1:0]   o_panel_change_valid;
  logic [N_PANELS-1:0]   o_panel_no_change;
  logic [3:0]            o_panel_product_code;
  logic [3:0]            o_panel_change_code;
  logic                  o_timeout;
  logic [3:0]            o_vm_product_code;
  logic                  o_vm_buy;
  logic [3:0]            o_vm_money;
  logic                  o_vm_money_valid;
  logic                  i_vm_product_valid;
  logic [3:0]            i_vm_product_code;
  logic                  i_vm_busy;
  logic [3:0]            i_vm_change_code;
  logic                  i_vm_change_valid;
  logic                  i_vm_no_change;

  modport slave (
    input  i_req, i_req_product_code, i_req_money, i_req_money_valid,
    input  i_vm_product_valid, i_vm_product_code, i_vm_busy,
    input  i_vm_change_code, i_vm_change_valid, i_vm_no_change,
    output o_gnt, o_money_ready, o_reject, o_done,
    output o_panel_product_valid, o_panel_change_valid, o_panel_no_change,
    output o_panel_product_code, o_panel_change_code, o_timeout,
    output o_vm_product_code, o_vm_buy, o_vm_money, o_vm_money_valid
  );

  modport master (
    output i_req, i_req_product_code, i_req_money, i_req_money_valid,
    output i_vm_product_valid, i_vm_product_code, i_vm_busy,
    output i_vm_change_code, i_vm_change_valid, i_vm_no_change,
    input  o_gnt, o_money_ready, o_reject, o_done,
    input  o_panel_product_valid, o_panel_change_valid, o_panel_no_change,
    input  o_panel_product_code, o_panel_change_code, o_timeout,
    input  o_vm_product_code, o_vm_buy, o_vm_money, o_vm_money_valid
  );
endinterface

// File: rtl/vm_rr_picker.sv
// Combinational round-robin picker: first set request strictly after ptr,
// wrapping modulo N; one-hot result plus an any-request flag.
module vm_rr_picker #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic             any_req
);
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt     = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = PTR_W'((32'(ptr) + k) % N);
      if (!any_req && req[idx]) begin
        gnt[idx] = 1'b1;
        any_req  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/vm_panel_arbiter.sv
// Round-robin arbiter sharing one vending machine core among N_PANELS panels;
// the grant is held for a whole select/money/deliver/change transaction.
module vm_panel_arbiter
  import vm_pkg::*;
#(
  parameter int unsigned N_PANELS         = 4,
  parameter int unsigned WATCHDOG_CYCLES  = 4096,
  parameter int unsigned MAX_PRODUCT_CODE = MAX_PRODUCT_CODE_DEF
) (
  input logic              i_clk,
  input logic              i_rst_n,
  vm_panel_arbiter_if.slave bus
);
  localparam int unsigned PTR_W = (N_PANELS > 1) ? $clog2(N_PANELS) : 1;
  localparam int unsigned WD_W  = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [CODE_W-1:0] MAX_CODE = CODE_W'(MAX_PRODUCT_CODE);

  arb_state_t          state;
  logic [N_PANELS-1:0] gnt, req_ok, req_bad, pick_gnt;
  logic                pick_any;
  logic [PTR_W-1:0]    ptr, gnt_idx, pick_idx;
  logic [WD_W-1:0]     wd_cnt;

  always_comb begin
    req_ok   = '0;
    req_bad  = '0;
    pick_idx = '0;
    for (int unsigned i = 0; i < N_PANELS; i++) begin
      if (bus.i_req[i]) begin
        if (bus.i_req_product_code[CODE_W*i +: CODE_W] != PRODUCT_NONE &&
            bus.i_req_product_code[CODE_W*i +: CODE_W] <= MAX_CODE)
          req_ok[i] = 1'b1;
        else
          req_bad[i] = 1'b1;
      end
      if (pick_gnt[i]) pick_idx = PTR_W'(i);
    end
  end

  vm_rr_picker #(.N(N_PANELS), .PTR_W(PTR_W)) u_picker (
    .req     (req_ok),
    .ptr     (ptr),
    .gnt     (pick_gnt),
    .any_req (pick_any)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state                 <= IDLE;
      gnt                   <= '0;
      gnt_idx               <= '0;
      ptr                   <= PTR_W'(N_PANELS - 1);
      wd_cnt                <= '0;
      bus.o_reject          <= '0;
      bus.o_done            <= '0;
      bus.o_vm_product_code <= PRODUCT_NONE;
      bus.o_vm_buy          <= 1'b0;
      bus.o_vm_money        <= DENOM_NONE;
      bus.o_vm_money_valid  <= 1'b0;
      bus.o_timeout         <= 1'b0;
    end else begin
      bus.o_reject         <= '0;
      bus.o_done           <= '0;
      bus.o_vm_buy         <= 1'b0;
      bus.o_vm_money_valid <= 1'b0;
      bus.o_timeout        <= 1'b0;
      case (state)
        IDLE: begin
          bus.o_reject <= req_bad;
          if (pick_any) begin
            gnt                   <= pick_gnt;
            gnt_idx               <= pick_idx;
            bus.o_vm_product_code <= bus.i_req_product_code[CODE_W*pick_idx +: CODE_W];
            state                 <= SELECT;
          end
        end
        SELECT: begin
          bus.o_vm_buy <= 1'b1;
          state        <= MONEY;
        end
        MONEY: begin
          if (bus.i_vm_busy) begin
            wd_cnt <= '0;
            state  <= DRAIN;
          end else begin
            bus.o_vm_money_valid <= bus.i_req_money_valid[gnt_idx];
            bus.o_vm_money       <= bus.i_req_money[CODE_W*gnt_idx +: CODE_W];
            // Saturate at WATCHDOG_CYCLES-1 so the pulse fires once per stall
            if (wd_cnt != WD_W'(WATCHDOG_CYCLES - 1)) begin
              wd_cnt <= wd_cnt + 1'b1;
              if (wd_cnt == WD_W'(WATCHDOG_CYCLES - 2)) bus.o_timeout <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (!bus.i_vm_busy) begin
            bus.o_done <= gnt;
            ptr        <= gnt_idx;
            gnt        <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_gnt                 = gnt;
  assign bus.o_money_ready         = (state == MONEY) ? gnt : '0;
  assign bus.o_panel_product_valid = (state == DRAIN) ? (gnt & {N_PANELS{bus.i_vm_product_valid}}) : '0;
  assign bus.o_panel_change_valid  = (state == DRAIN) ? (gnt & {N_PANELS{bus.i_vm_change_valid}}) : '0;
  assign bus.o_panel_no_change     = (state == DRAIN) ? (gnt & {N_PANELS{bus.i_vm_no_change}}) : '0;
  assign bus.o_panel_product_code  = bus.i_vm_product_code;
  assign bus.o_panel_change_code   = bus.i_vm_change_code;
endmodule

// File: tb/tb_vm_panel_arbiter.sv
// Self-checking bench for vm_panel_arbiter: transaction-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_vm_panel_arbiter;
  import vm_pkg::*;

  localparam int N  = 4;
  localparam int WD = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vm_panel_arbiter_if #(.N_PANELS(N)) bus ();

  vm_panel_arbiter #(.N_PANELS(N), .WATCHDOG_CYCLES(WD), .MAX_PRODUCT_CODE(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t: wait bound expired", name, $time);
  endtask

  // Reference model: who owns the core and which transaction phase it is in
  int         m_phase;  // 0 idle, 1 select, 2 money, 3 drain
  int         m_owner;
  int         m_last;
  int         m_wait;
  logic [3:0] m_reject, m_done;
  logic       m_buy, m_mv, m_tout;
  logic [3:0] m_code, m_money;

  function automatic logic [3:0] pcode(input int i);
    return bus.i_req_product_code[4*i +: 4];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_owner = -1; m_last = N - 1; m_wait = 0;
      m_reject = '0; m_done = '0; m_buy = 0; m_mv = 0; m_tout = 0;
      m_code = '0; m_money = '0;
    end else begin
      int ph;
      bit found;
      ph = m_phase;
      m_reject = '0; m_done = '0; m_buy = 0; m_mv = 0; m_tout = 0;
      if (ph == 0) begin
        found = 0;
        for (int i = 0; i < N; i++)
          if (bus.i_req[i] && (pcode(i) == 0 || pcode(i) > 8)) m_reject[i] = 1'b1;
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (!found && bus.i_req[c] && pcode(c) >= 1 && pcode(c) <= 8) begin
            found = 1; m_owner = c; m_code = pcode(c); m_phase = 1;
          end
        end
      end else if (ph == 1) begin
        m_buy = 1; m_phase = 2; m_wait = 0;
      end else if (ph == 2) begin
        if (bus.i_vm_busy) begin
          m_phase = 3; m_wait = 0;
        end else begin
          m_mv    = bus.i_req_money_valid[m_owner];
          m_money = bus.i_req_money[4*m_owner +: 4];
          if (m_wait < WD - 1) begin
            m_wait++;
            if (m_wait == WD - 1) m_tout = 1;
          end
        end
      end else begin
        if (!bus.i_vm_busy) begin
          m_done[m_owner] = 1'b1; m_last = m_owner; m_owner = -1; m_phase = 0;
        end
      end
    end
  end

  // Observation counters for the directed scenarios
  int         n_buy = 0, n_beats = 0, n_tout = 0;
  logic [3:0] last_money = '0;
  logic [3:0] prev_gnt = '0;
  int         glog[$];

  always @(posedge clk) begin
    logic [3:0] eg, own;
    #1;
    own = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    eg  = own;
    chk("gnt", bus.o_gnt, eg);
    chk("reject", bus.o_reject, m_reject);
    chk("done", bus.o_done, m_done);
    chk("buy", bus.o_vm_buy, m_buy);
    chk("vm_code", bus.o_vm_product_code, m_code);
    chk("money_valid", bus.o_vm_money_valid, m_mv);
    if (m_mv) chk("money", bus.o_vm_money, m_money);
    chk("money_ready", bus.o_money_ready, (m_phase == 2) ? own : 4'b0000);
    chk("timeout", bus.o_timeout, m_tout);
    chk("panel_pv", bus.o_panel_product_valid, (m_phase == 3 && bus.i_vm_product_valid) ? own : 4'b0000);
    chk("panel_cv", bus.o_panel_change_valid, (m_phase == 3 && bus.i_vm_change_valid) ? own : 4'b0000);
    chk("panel_nc", bus.o_panel_no_change, (m_phase == 3 && bus.i_vm_no_change) ? own : 4'b0000);
    chk("panel_pcode", bus.o_panel_product_code, bus.i_vm_product_code);
    chk("panel_ccode", bus.o_panel_change_code, bus.i_vm_change_code);
    if (bus.o_vm_buy) n_buy++;
    if (bus.o_vm_money_valid) begin n_beats++; last_money = bus.o_vm_money; end
    if (bus.o_timeout) n_tout++;
    if (prev_gnt == 0 && bus.o_gnt != 0)
      for (int i = 0; i < N; i++) if (bus.o_gnt[i]) glog.push_back(i);
    prev_gnt = bus.o_gnt;
  end

  task automatic wait_gnt(input string tag);
    int n = 0;
    while (bus.o_gnt == 0 && n < 20) begin @(negedge clk); n++; end
    if (bus.o_gnt == 0) bound_fail(tag);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (bus.o_money_ready == 0 && n < 10) begin @(negedge clk); n++; end
    if (bus.o_money_ready == 0) bound_fail(tag);
  endtask

  task automatic finish_txn(input string tag);
    int n = 0;
    bus.i_vm_busy = 1'b1;
    @(negedge clk);
    bus.i_vm_busy = 1'b0;
    @(negedge clk);
    while (bus.o_done == 0 && n < 10) begin @(negedge clk); n++; end
    if (bus.o_done == 0) bound_fail(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "simulation time limit");
  end

  initial begin
    bus.i_req = '0; bus.i_req_product_code = '0; bus.i_req_money = '0;
    bus.i_req_money_valid = '0; bus.i_vm_product_valid = 0; bus.i_vm_product_code = '0;
    bus.i_vm_busy = 0; bus.i_vm_change_code = '0; bus.i_vm_change_valid = 0;
    bus.i_vm_no_change = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", bus.o_gnt, 4'b0000);
    chk("rst_vm_code", bus.o_vm_product_code, 4'd0);
    rst_n = 1'b1;

    // Single request: panel 0, code 3, two 200 beats
    @(negedge clk);
    bus.i_req[0] = 1'b1; bus.i_req_product_code[3:0] = 4'd3;
    @(negedge clk);
    chk("t1_gnt", bus.o_gnt, 4'b0001);
    chk("t1_code", bus.o_vm_product_code, 4'd3);
    bus.i_req[0] = 1'b0; bus.i_req_product_code[3:0] = 4'd15;
    @(negedge clk);
    chk("t1_buy", bus.o_vm_buy, 1'b1);
    chk("t1_ready", bus.o_money_ready, 4'b0001);
    bus.i_req_money_valid[0] = 1'b1; bus.i_req_money[3:0] = DENOM_200;
    @(negedge clk);
    chk("t1_mv1", bus.o_vm_money_valid, 1'b1);
    chk("t1_money1", bus.o_vm_money, 4'd2);
    @(negedge clk);
    chk("t1_mv2", bus.o_vm_money_valid, 1'b1);
    bus.i_req_money_valid[0] = 1'b0; bus.i_vm_busy = 1'b1;
    @(negedge clk);
    chk("t1_mv_drop", bus.o_vm_money_valid, 1'b0);
    chk("t1_ready_drop", bus.o_money_ready, 4'b0000);
    bus.i_vm_product_valid = 1'b1; bus.i_vm_product_code = 4'd3;
    #1;
    chk("t1_pv_route", bus.o_panel_product_valid, 4'b0001);
    @(negedge clk);
    bus.i_vm_product_valid = 1'b0; bus.i_vm_busy = 1'b0;
    @(negedge clk);
    chk("t1_done", bus.o_done, 4'b0001);
    chk("t1_beats", n_beats, 2);
    chk("t1_buys", n_buy, 1);

    // Invalid codes: panel 1 code 0, panel 2 code 9, panel 3 code 5
    bus.i_req = 4'b1110;
    bus.i_req_product_code = {4'd5, 4'd9, 4'd0, 4'd0};
    @(negedge clk);
    chk("inv_reject", bus.o_reject, 4'b0110);
    chk("inv_gnt", bus.o_gnt, 4'b1000);
    bus.i_req = '0;
    wait_ready("inv_ready");
    finish_txn("inv_done");

    // Watchdog: panel 1 holds the grant without paying
    bus.i_req[1] = 1'b1; bus.i_req_product_code[7:4] = 4'd7;
    wait_gnt("wd_gnt");
    bus.i_req[1] = 1'b0;
    n_tout = 0;
    repeat (20) @(negedge clk);
    chk("wd_pulses", n_tout, 1);
    chk("wd_ready", bus.o_money_ready, 4'b0010);
    bus.i_req_money_valid[1] = 1'b1; bus.i_req_money[7:4] = DENOM_100;
    @(negedge clk);
    bus.i_req_money_valid[1] = 1'b0;
    finish_txn("wd_done");

    // Reset in the middle of MONEY
    bus.i_req[1] = 1'b1; bus.i_req_product_code[7:4] = 4'd2;
    wait_gnt("rst_gnt_wait");
    bus.i_req[1] = 1'b0;
    wait_ready("rst_ready");
    bus.i_req_money_valid[1] = 1'b1; bus.i_req_money[7:4] = DENOM_500;
    @(negedge clk);
    chk("rst_pre_mv", bus.o_vm_money_valid, 1'b1);
    bus.i_req = 4'b1101;
    bus.i_req_product_code = {4'd4, 4'd2, 4'd0, 4'd1};
    rst_n = 1'b0;
    #1;
    chk("rst_async_gnt", bus.o_gnt, 4'b0000);
    chk("rst_async_mv", bus.o_vm_money_valid, 1'b0);
    chk("rst_async_ready", bus.o_money_ready, 4'b0000);
    bus.i_req_money_valid[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    glog.delete();

    // Contention: panels 0, 2, 3 keep requesting
    for (int t = 0; t < 4; t++) begin
      wait_gnt("cont_gnt");
      wait_ready("cont_ready");
      finish_txn("cont_done");
    end
    bus.i_req = '0;
    chk("cont_len", glog.size(), 4);
    if (glog.size() == 4) begin
      chk("cont_g0", glog[0], 0);
      chk("cont_g1", glog[1], 2);
      chk("cont_g2", glog[2], 3);
      chk("cont_g3", glog[3], 0);
      for (int i = 0; i < 3; i++) chk("cont_norepeat", glog[i] == glog[i+1], 0);
    end

    // Isolation: panel 2 owns the core, panel 1 waves money around
    bus.i_req_money_valid[1] = 1'b1; bus.i_req_money[7:4] = 4'd5;
    bus.i_req[2] = 1'b1; bus.i_req_product_code[11:8] = 4'd6;
    n_beats = 0;
    wait_gnt("iso_gnt");
    chk("iso_gnt_val", bus.o_gnt, 4'b0100);
    bus.i_req[2] = 1'b0;
    wait_ready("iso_ready");
    bus.i_req_money_valid[2] = 1'b1; bus.i_req_money[11:8] = DENOM_500;
    @(negedge clk);
    bus.i_req_money_valid[2] = 1'b0;
    @(negedge clk);
    chk("iso_beats", n_beats, 1);
    chk("iso_money", last_money, 4'd3);
    bus.i_vm_busy = 1'b1;
    @(negedge clk);
    bus.i_vm_change_valid = 1'b1; bus.i_vm_change_code = 4'd8;
    #1;
    chk("iso_cv", bus.o_panel_change_valid, 4'b0100);
    chk("iso_ccode", bus.o_panel_change_code, 4'd8);
    chk("iso_pv", bus.o_panel_product_valid, 4'b0000);
    @(negedge clk);
    bus.i_vm_change_valid = 1'b0;
    finish_txn("iso_done");
    chk("iso_done_val", bus.o_done, 4'b0100);
    bus.i_req_money_valid[1] = 1'b0;

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
